flappy_game_ctrl: RTL
=====================

Name: flappy_game_ctrl

Overview:
- Top-level game sequencer: owns the game state machine and drives the pipe generator's game-reset and move-enable inputs.
- Generates the frame tick and detects flap edges, collision and pipe-pass scoring.
- Sits between the button/collision logic and pipe_generator, bird physics and the score display.

Parameters:
TICK_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz); must be >= 2.
BIRD_X, 200, fixed bird left-edge x coordinate in pixels.
PIPE_W, 60, pipe width in pixels.
DEATH_FRAMES, 30, frame ticks spent in DYING before GAME_OVER; must be >= 1.
SCORE_W, 8, score counter width.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous active-high reset.
flap_btn  input  1  flap button level, already synchronized to clk.
collision  input  1  bird/pipe/ground overlap flag, sampled every cycle.
pipe_x  input  11  current pipe left-edge x from pipe_generator.
frame_tick  output  1  one-cycle pulse every TICK_DIV cycles, free-running.
pipe_move  output  1  drives pipe_generator bird_move; one-cycle step pulse.
reset_game  output  1  drives pipe_generator RESET_GAME.
bird_flap  output  1  one-cycle flap impulse to bird physics.
score  output  SCORE_W  pipes passed this game.
state  output  2  0 IDLE, 1 PLAYING, 2 DYING, 3 GAME_OVER.
game_over  output  1  high while in GAME_OVER.

Behaviour:
- Reset values: state=IDLE, reset_game=1, pipe_move=0, bird_flap=0, frame_tick=0, score=0, game_over=0, tick counter=0, death counter=0.
- Reset behaves identically when asserted mid-game. All outputs are registered.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps; frame_tick=1 in the cycle after the counter reaches TICK_DIV-1.
  - Runs in every state and is never reset by the FSM.
- Flap edge: flap_btn is registered; flap_evt = flap_btn & ~flap_btn_q. A held button produces exactly one event.
- IDLE:
  - reset_game=1, pipe_move=0.
  - On flap_evt: go to PLAYING, clear score to 0, pulse bird_flap, deassert reset_game on the same edge.
- PLAYING:
  - reset_game=0; pipe_move=frame_tick (registered copy, 1-cycle latency); bird_flap pulses 1 cycle after each flap_evt.
  - collision=1 -> DYING on the next edge.
- Scoring (PLAYING only):
  - right = pipe_x + PIPE_W, computed at 12 bits to avoid overflow.
  - Register right_q each cycle. Score increments when right_q >= BIRD_X and right < BIRD_X.
  - Pipe respawn (right jumps high) never scores. Score saturates at all-ones.
  - Score and collision in the same cycle: collision wins, no increment.
- DYING:
  - pipe_move=0, bird_flap suppressed, death counter increments on each frame_tick.
  - After DEATH_FRAMES ticks -> GAME_OVER; death counter clears on entry.
- GAME_OVER:
  - game_over=1, pipe_move=0, score held.
  - flap_evt -> IDLE (reset_game reasserts next cycle).
  - The flap that leaves GAME_OVER does not also start a game; a new flap is required in IDLE.
- collision is ignored outside PLAYING.
- flap_evt and collision in the same PLAYING cycle: transition to DYING; the bird_flap pulse is still emitted.

Optional Feature:
HIGH_SCORE_EN
- Defined: adds output high_score [SCORE_W-1:0], reset to 0.
  - On entry to GAME_OVER, high_score <= max(high_score, score).
  - Survives game restarts; cleared only by rst.
- Not defined: no high_score port or register; all other behaviour unchanged.

Test Plan:
- Bench parameters for all scenarios: TICK_DIV=4, DEATH_FRAMES=3, BIRD_X=200, PIPE_W=60.
- rst=1 for 50 ns, then release -> state=0, reset_game=1, score=0; frame_tick pulses every 4 clk; pipe_move stays 0.
- flap_btn held high for 10 clk in IDLE -> exactly one bird_flap pulse; state=1; reset_game=0 next cycle; pipe_move pulses once per 4 clk.
- PLAYING, drive pipe_x 141 -> 140 -> 139 -> score stays 0 then becomes 1 after the 140 -> 139 step. pipe_x 139 -> 640 -> no change.
- PLAYING, collision=1 in the same cycle as pipe_x 140 -> 139 -> score unchanged, state=2; exactly 3 frame_ticks later state=3, game_over=1, pipe_move=0 throughout.
- GAME_OVER, flap -> state=0, reset_game=1; second flap -> state=1, score=0. rst mid-PLAYING -> all outputs return to reset values immediately.
- HIGH_SCORE_EN defined: games scoring 3 then 1 -> high_score=3 after both.

Source files
------------

// File: rtl/flappy_game_ctrl.sv
// -----------------------------------------------------------------------------
// flappy_game_ctrl
//
// Top-level game sequencer for the flappy-bird style game. Owns the game state
// machine (IDLE -> PLAYING -> DYING -> GAME_OVER -> IDLE). It generates the
// free-running frame tick, turns the flap button level into single flap
// events, scores pipes as their right edge passes the bird, and drives the
// pipe generator's game-reset and move-enable inputs.
//
// Optional feature (compile-time macro HIGH_SCORE_EN):
//   defined     -> adds output high_score, updated on entry to GAME_OVER and
//                  cleared only by rst.
//   not defined -> no high_score port or register.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   flap_btn   in   flap button level, already synchronized to clk
//   collision  in   bird/pipe/ground overlap flag (used in PLAYING only)
//   pipe_x     in   [10:0] current pipe left-edge x from pipe_generator
//   frame_tick out  one-cycle pulse every TICK_DIV cycles, free-running
//   pipe_move  out  one-cycle pipe step pulse to pipe_generator
//   reset_game out  holds pipe_generator in reset outside of a game
//   bird_flap  out  one-cycle flap impulse to bird physics
//   score      out  [SCORE_W-1:0] pipes passed this game (saturating)
//   state      out  [1:0] 0 IDLE, 1 PLAYING, 2 DYING, 3 GAME_OVER
//   game_over  out  high while in GAME_OVER
//   high_score out  [SCORE_W-1:0] best score since rst (HIGH_SCORE_EN only)
// -----------------------------------------------------------------------------
module flappy_game_ctrl #(
  parameter int TICK_DIV     = 833333,
  parameter int BIRD_X       = 200,
  parameter int PIPE_W       = 60,
  parameter int DEATH_FRAMES = 30,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flap_btn,
  input  logic               collision,
  input  logic [10:0]        pipe_x,
  output logic               frame_tick,
  output logic               pipe_move,
  output logic               reset_game,
  output logic               bird_flap,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state,
  output logic               game_over
`ifdef HIGH_SCORE_EN
  ,
  output logic [SCORE_W-1:0] high_score
`endif
);

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int DEATH_W = $clog2(DEATH_FRAMES + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_FRAMES - 1);
  localparam logic [11:0]        BIRD_X_12  = 12'(BIRD_X);
  localparam logic [11:0]        PIPE_W_12  = 12'(PIPE_W);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PLAYING   = 2'd1,
    ST_DYING     = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic                 r_frame_tick;
  logic                 r_flap_q;
  logic [11:0]          r_right_q;
  logic [DEATH_W-1:0]   r_death_cnt;
  logic [DEATH_W-1:0]   w_death_cnt_d;
  logic [SCORE_W-1:0]   r_score;
  logic [SCORE_W-1:0]   w_score_d;
  logic                 r_pipe_move;
  logic                 w_pipe_move_d;
  logic                 r_bird_flap;
  logic                 w_bird_flap_d;
  logic                 r_reset_game;
  logic                 r_game_over;

  logic                 w_flap_evt;
  logic [11:0]          w_right;
  logic                 w_pass;

  // Rising edge of the button level: a held button yields one event.
  assign w_flap_evt = flap_btn & ~r_flap_q;

  // Right edge at 12 bits so pipe_x near 2047 plus PIPE_W cannot wrap.
  assign w_right = {1'b0, pipe_x} + PIPE_W_12;

  // The right edge crossed the bird's left edge this cycle. A respawn makes
  // the right edge jump upward, so it can never satisfy this.
  assign w_pass = (r_right_q >= BIRD_X_12) && (w_right < BIRD_X_12);

  // Free-running frame tick; the FSM never touches it.
  // NOTE: all clocked state is assigned with <= so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= (r_tick_cnt == TICK_LAST);
      r_tick_cnt   <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
    end
  end

  // Next-state and next-output logic.
  // NOTE: every signal written here gets a default before the case statement
  // so no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_death_cnt_d = r_death_cnt;
    w_score_d     = r_score;
    w_pipe_move_d = 1'b0;
    w_bird_flap_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_flap_evt) begin
          w_next_state  = ST_PLAYING;
          w_score_d     = '0;
          w_bird_flap_d = 1'b1;
        end
      end
      ST_PLAYING: begin
        // The flap impulse is still emitted on the cycle the bird dies.
        w_bird_flap_d = w_flap_evt;
        if (collision) begin
          // Collision wins over a simultaneous pass: no increment.
          w_next_state  = ST_DYING;
          w_death_cnt_d = '0;
        end else begin
          w_pipe_move_d = r_frame_tick;
          if (w_pass && (r_score != '1)) begin
            w_score_d = r_score + 1'b1;
          end
        end
      end
      ST_DYING: begin
        if (r_frame_tick) begin
          if (r_death_cnt == DEATH_LAST) begin
            w_next_state = ST_GAME_OVER;
          end else begin
            w_death_cnt_d = r_death_cnt + 1'b1;
          end
        end
      end
      ST_GAME_OVER: begin
        // Only returns to IDLE; starting a game needs a fresh edge there.
        if (w_flap_evt) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_flap_q     <= 1'b0;
      r_right_q    <= '0;
      r_death_cnt  <= '0;
      r_score      <= '0;
      r_pipe_move  <= 1'b0;
      r_bird_flap  <= 1'b0;
      r_reset_game <= 1'b1;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_flap_q     <= flap_btn;
      r_right_q    <= w_right;
      r_death_cnt  <= w_death_cnt_d;
      r_score      <= w_score_d;
      r_pipe_move  <= w_pipe_move_d;
      r_bird_flap  <= w_bird_flap_d;
      r_reset_game <= (w_next_state == ST_IDLE);
      r_game_over  <= (w_next_state == ST_GAME_OVER);
    end
  end

`ifdef HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_high_score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_score <= '0;
    end else if ((r_state == ST_DYING) && (w_next_state == ST_GAME_OVER) &&
                 (r_score > r_high_score)) begin
      r_high_score <= r_score;
    end
  end

  assign high_score = r_high_score;
`endif

  assign frame_tick = r_frame_tick;
  assign pipe_move  = r_pipe_move;
  assign reset_game = r_reset_game;
  assign bird_flap  = r_bird_flap;
  assign score      = r_score;
  assign state      = r_state;
  assign game_over  = r_game_over;

endmodule
